c_element_hs_seq: RTL and testbench
===================================

C_ELEMENT_HS_SEQ -- requirements
Module: c_element_hs_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flip-flops in the c_i synchronizer (minimum 2).
REQ-002 SHALL have port wb_clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start_i, input, 1: begin a run; sampled only in IDLE.
REQ-005 SHALL have port n_cycles_i, input, 8: number of full 4-phase handshakes to run; latched at start.
REQ-006 SHALL have port skew_i, input, 4: cycles between first and second input edge; latched at start.
REQ-007 SHALL have port order_i, input, 1: 0 means a_o leads, 1 means b_o leads; latched at start.
REQ-008 SHALL have port timeout_i, input, 8: maximum wait cycles for c; 0 disables the timeout; latched at start.
REQ-009 SHALL have port c_i, input, 1: asynchronous output of the external Muller C-element.
REQ-010 SHALL have ports a_o and b_o, output, 1 each: registered drives to the C-element inputs.
REQ-011 SHALL have port busy_o, output, 1: high in any state other than IDLE.
REQ-012 SHALL have port done_o, output, 1: one-cycle pulse when a run completes without error.
REQ-013 SHALL have port err_o, output, 1: sticky error flag.
REQ-014 SHALL have port err_code_o, output, 2: 00 none, 01 early fire, 10 timeout high, 11 timeout low.
REQ-015 SHALL have port pass_cnt_o, output, 8: count of completed handshakes in the current or last run.

Function
REQ-016 SHALL pass c_i through a SYNC_STAGES flip-flop synchronizer; every internal use of c refers to the synchronized value c_s.
REQ-017 SHALL implement states IDLE, SKEW_UP, WAIT_HI, SKEW_DN, WAIT_LO, DONE.
REQ-018 In IDLE with start_i=1, SHALL latch the inputs, clear pass_cnt_o, err_o and err_code_o, and go to DONE if n_cycles_i=0, otherwise to SKEW_UP.
REQ-019 On entry to SKEW_UP, SHALL drive the leading input high in the next cycle after start acceptance; if skew=0, both inputs rise in that same cycle and the FSM goes directly to WAIT_HI.
REQ-020 In SKEW_UP, SHALL hold the leading input high for skew cycles, then raise the lagging input and enter WAIT_HI.
REQ-021 In SKEW_UP, SHALL flag early fire (code 01) if c_s=1.
REQ-022 In WAIT_HI, SHALL go to SKEW_DN when c_s=1, dropping the leading input in the same transition.
REQ-023 In SKEW_DN, SHALL hold skew cycles, then drop the lagging input and enter WAIT_LO; if skew=0, both inputs fall together.
REQ-024 In SKEW_DN, SHALL flag early fire (code 01) if c_s=0.
REQ-025 In WAIT_LO on c_s=0, SHALL increment pass_cnt_o and go to DONE if pass_cnt+1 equals n_cycles, otherwise to SKEW_UP.
REQ-026 SHALL count cycles spent in WAIT_HI and WAIT_LO with a counter cleared on each entry.
REQ-027 If timeout_i is nonzero and the wait counter reaches timeout_i, SHALL flag code 10 (in WAIT_HI) or 11 (in WAIT_LO).
REQ-028 On any error, SHALL set err_o=1 and err_code_o, force a_o=b_o=0, and return to IDLE in the next cycle without pulsing done_o.
REQ-029 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-030 SHALL ignore start_i while busy_o=1.
REQ-031 pass_cnt_o SHALL saturate at 255 and never wrap.
REQ-032 err_o and err_code_o SHALL hold until the next accepted start or reset.

Reset
REQ-033 With wb_rst_i=1, SHALL force state IDLE, a_o=b_o=0, busy_o=0, done_o=0, err_o=0, err_code_o=00, pass_cnt_o=0 and synchronizer flops to 0 at the next edge.
REQ-034 Reset mid-run SHALL take priority over all transitions; inputs fall the cycle after reset is sampled and no done_o is produced.

Verification
REQ-035 Ideal C-element model, n=3, skew=2, order=0, timeout=20 -> a_o leads b_o by 2 cycles on each edge, pass_cnt_o=3, one done_o pulse, err_o=0.
REQ-036 n=0, start -> done_o pulse 1 cycle after start, a_o and b_o never rise, pass_cnt_o=0.
REQ-037 Model forces c=1 during SKEW_UP with skew=5 -> err_code_o=01, a_o=b_o=0, busy_o=0, no done_o.
REQ-038 c stuck at 0, timeout=10 -> err_code_o=10 after 10 WAIT_HI cycles; with timeout=0, the controller waits indefinitely and busy_o stays 1.
REQ-039 skew=0, order=1, n=2 -> a_o and b_o toggle in the same cycles, pass_cnt_o=2; start pulses mid-run are ignored.
REQ-040 Assert wb_rst_i during WAIT_HI of handshake 2 -> all outputs reach reset values on the next edge; a new start then runs cleanly.

Source files
------------

// File: rtl/c_element_hs_seq.sv
// Sequencer that runs repeated 4-phase handshakes through an external Muller C-element,
// with programmable input skew and ordering, a wait timeout, and early-fire detection.
module c_element_hs_seq #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       start_i,
  input  logic [7:0] n_cycles_i,
  input  logic [3:0] skew_i,
  input  logic       order_i,
  input  logic [7:0] timeout_i,
  input  logic       c_i,
  output logic       a_o,
  output logic       b_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [1:0] err_code_o,
  output logic [7:0] pass_cnt_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SKEW_UP = 3'd1,
    WAIT_HI = 3'd2,
    SKEW_DN = 3'd3,
    WAIT_LO = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_EARLY = 2'b01;
  localparam logic [1:0] CODE_TO_HI = 2'b10;
  localparam logic [1:0] CODE_TO_LO = 2'b11;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   c_s;
  logic                   a_q, a_d;
  logic                   b_q, b_d;
  logic [7:0]             n_q, n_d;
  logic [3:0]             skew_q, skew_d;
  logic                   order_q, order_d;
  logic [7:0]             tmo_q, tmo_d;
  logic [7:0]             pass_q, pass_d;
  logic                   err_q, err_d;
  logic [1:0]             code_q, code_d;
  logic [3:0]             skew_cnt_q, skew_cnt_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;

  logic                   go_up;
  logic                   go_dn;
  logic                   fault;
  logic [1:0]             fault_code;
  logic                   tmo_hit;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], c_i};
  assign c_s    = sync_q[SYNC_STAGES-1];

  assign tmo_hit = (tmo_q != 8'd0) && (({1'b0, wait_cnt_q} + 9'd1) == {1'b0, tmo_q});

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    n_d        = n_q;
    skew_d     = skew_q;
    order_d    = order_q;
    tmo_d      = tmo_q;
    pass_d     = pass_q;
    err_d      = err_q;
    code_d     = code_q;
    skew_cnt_d = skew_cnt_q;
    wait_cnt_d = wait_cnt_q;
    go_up      = 1'b0;
    go_dn      = 1'b0;
    fault      = 1'b0;
    fault_code = CODE_NONE;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          n_d     = n_cycles_i;
          skew_d  = skew_i;
          order_d = order_i;
          tmo_d   = timeout_i;
          pass_d  = '0;
          err_d   = 1'b0;
          code_d  = CODE_NONE;
          if (n_cycles_i == 8'd0) state_d = DONE;
          else                    go_up   = 1'b1;
        end
      end

      SKEW_UP: begin
        if (c_s) begin
          fault      = 1'b1;
          fault_code = CODE_EARLY;
        end else if (skew_cnt_q == skew_q - 4'd1) begin
          if (order_q) a_d = 1'b1;
          else         b_d = 1'b1;
          wait_cnt_d = '0;
          state_d    = WAIT_HI;
        end else begin
          skew_cnt_d = skew_cnt_q + 4'd1;
        end
      end

      WAIT_HI: begin
        if (c_s) begin
          go_dn = 1'b1;
        end else if (tmo_hit) begin
          fault      = 1'b1;
          fault_code = CODE_TO_HI;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      SKEW_DN: begin
        if (!c_s) begin
          fault      = 1'b1;
          fault_code = CODE_EARLY;
        end else if (skew_cnt_q == skew_q - 4'd1) begin
          if (order_q) a_d = 1'b0;
          else         b_d = 1'b0;
          wait_cnt_d = '0;
          state_d    = WAIT_LO;
        end else begin
          skew_cnt_d = skew_cnt_q + 4'd1;
        end
      end

      WAIT_LO: begin
        if (!c_s) begin
          pass_d = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
          if (({1'b0, pass_q} + 9'd1) == {1'b0, n_q}) state_d = DONE;
          else                                         go_up   = 1'b1;
        end else if (tmo_hit) begin
          fault      = 1'b1;
          fault_code = CODE_TO_LO;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Start of a rising phase; zero skew bypasses SKEW_UP so both inputs move together.
    if (go_up) begin
      if (order_d) b_d = 1'b1;
      else         a_d = 1'b1;
      if (skew_d == 4'd0) begin
        a_d        = 1'b1;
        b_d        = 1'b1;
        wait_cnt_d = '0;
        state_d    = WAIT_HI;
      end else begin
        skew_cnt_d = '0;
        state_d    = SKEW_UP;
      end
    end

    if (go_dn) begin
      if (order_q) b_d = 1'b0;
      else         a_d = 1'b0;
      if (skew_q == 4'd0) begin
        a_d        = 1'b0;
        b_d        = 1'b0;
        wait_cnt_d = '0;
        state_d    = WAIT_LO;
      end else begin
        skew_cnt_d = '0;
        state_d    = SKEW_DN;
      end
    end

    if (fault) begin
      err_d   = 1'b1;
      code_d  = fault_code;
      a_d     = 1'b0;
      b_d     = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      n_q        <= '0;
      skew_q     <= '0;
      order_q    <= 1'b0;
      tmo_q      <= '0;
      pass_q     <= '0;
      err_q      <= 1'b0;
      code_q     <= CODE_NONE;
      skew_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      a_q        <= a_d;
      b_q        <= b_d;
      n_q        <= n_d;
      skew_q     <= skew_d;
      order_q    <= order_d;
      tmo_q      <= tmo_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      code_q     <= code_d;
      skew_cnt_q <= skew_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign a_o        = a_q;
  assign b_o        = b_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign err_o      = err_q;
  assign err_code_o = code_q;
  assign pass_cnt_o = pass_q;

endmodule

// File: tb/tb_c_element_hs_seq.sv
// Scoreboard bench for c_element_hs_seq: a behavioural C-element drives c_i, and each
// run's expected end-of-run outputs are queued and checked when the run terminates.
module tb_c_element_hs_seq;

  logic       clk = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] n_cycles_i = '0;
  logic [3:0] skew_i = '0;
  logic       order_i = 1'b0;
  logic [7:0] timeout_i = '0;
  logic       c_model = 1'b0;
  logic       a_o, b_o, busy_o, done_o, err_o;
  logic [1:0] err_code_o;
  logic [7:0] pass_cnt_o;

  always #5 clk = ~clk;

  c_element_hs_seq #(.SYNC_STAGES(2)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .start_i    (start_i),
    .n_cycles_i (n_cycles_i),
    .skew_i     (skew_i),
    .order_i    (order_i),
    .timeout_i  (timeout_i),
    .c_i        (c_model),
    .a_o        (a_o),
    .b_o        (b_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_code_o (err_code_o),
    .pass_cnt_o (pass_cnt_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int mode = 0;  // 0 ideal C-element, 1 forced high, 2 stuck low

  always @(posedge clk) cyc++;

  always @(a_o or b_o or mode) begin
    #1;
    if (mode == 1)                 c_model = 1'b1;
    else if (mode == 2)            c_model = 1'b0;
    else if (a_o === 1'b1 && b_o === 1'b1) c_model = 1'b1;
    else if (a_o === 1'b0 && b_o === 1'b0) c_model = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic       done;
    logic       err;
    logic [1:0] code;
    logic [7:0] pass;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  function automatic void expect_end(input string nm, input logic d, input logic e,
                                     input logic [1:0] c, input logic [7:0] p);
    exp_t x;
    x.name = nm; x.done = d; x.err = e; x.code = c; x.pass = p;
    sb.push_back(x);
  endfunction

  logic prev_busy = 1'b0, prev_done = 1'b0, prev_a = 1'b0, prev_b = 1'b0, prev_err = 1'b0;
  int   a_tog[$];
  int   b_tog[$];
  int   err_cyc = -1;
  int   done_cyc = -1;

  // Run end = done pulse, or busy falling without a preceding done (error or reset).
  always @(negedge clk) begin
    if (a_o !== prev_a) a_tog.push_back(cyc);
    if (b_o !== prev_b) b_tog.push_back(cyc);
    if (err_o === 1'b1 && prev_err !== 1'b1) err_cyc = cyc;
    if (done_o === 1'b1) begin
      done_cyc = cyc;
      check("done_width", {31'd0, prev_done}, 32'd0);
    end
    if (done_o === 1'b1 || (prev_busy === 1'b1 && busy_o === 1'b0 && prev_done !== 1'b1)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_end actual=done%0d required=no_run_end", done_o);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_done"}, {31'd0, done_o}, {31'd0, mon_e.done});
        check({mon_e.name, "_err"},  {31'd0, err_o},  {31'd0, mon_e.err});
        check({mon_e.name, "_code"}, {30'd0, err_code_o}, {30'd0, mon_e.code});
        check({mon_e.name, "_pass"}, {24'd0, pass_cnt_o}, {24'd0, mon_e.pass});
        check({mon_e.name, "_ab"},   {30'd0, a_o, b_o}, 32'd0);
      end
    end
    prev_busy = busy_o;
    prev_done = done_o;
    prev_a    = a_o;
    prev_b    = b_o;
    prev_err  = err_o;
  end

  task automatic start_run(input logic [7:0] n, input logic [3:0] sk, input logic o, input logic [7:0] to);
    @(negedge clk);
    n_cycles_i = n; skew_i = sk; order_i = o; timeout_i = to;
    start_i = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int k = 0;
    while ((busy_o !== 1'b0 || sb.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_wait actual=busy required=idle_within_%0d", name, budget);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_logs();
    a_tog.delete();
    b_tog.delete();
    err_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_a"},    {31'd0, a_o}, 32'd0);
    check({nm, "_b"},    {31'd0, b_o}, 32'd0);
    check({nm, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({nm, "_done"}, {31'd0, done_o}, 32'd0);
    check({nm, "_err"},  {31'd0, err_o}, 32'd0);
    check({nm, "_code"}, {30'd0, err_code_o}, 32'd0);
    check({nm, "_pass"}, {24'd0, pass_cnt_o}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    wb_rst_i = 1'b0;
    repeat (2) @(negedge clk);

    // Ideal handshakes, a leads b by 2 on every edge
    clear_logs();
    expect_end("ideal", 1'b1, 1'b0, 2'b00, 8'd3);
    start_run(8'd3, 4'd2, 1'b0, 8'd20);
    wait_quiet("ideal", 400);
    check("ideal_a_toggles", a_tog.size(), 32'd6);
    check("ideal_b_toggles", b_tog.size(), 32'd6);
    if (a_tog.size() == 6 && b_tog.size() == 6)
      for (int i = 0; i < 6; i++) check("ideal_skew", b_tog[i] - a_tog[i], 32'd2);

    // Zero handshakes: immediate done, inputs never move
    clear_logs();
    expect_end("n0", 1'b1, 1'b0, 2'b00, 8'd0);
    start_run(8'd0, 4'd3, 1'b0, 8'd5);
    wait_quiet("n0", 50);
    check("n0_done_latency", done_cyc - start_cyc, 32'd1);
    check("n0_toggles", a_tog.size() + b_tog.size(), 32'd0);

    // Early fire: c forced high while still skewing up
    clear_logs();
    expect_end("early", 1'b0, 1'b1, 2'b01, 8'd0);
    start_run(8'd1, 4'd5, 1'b0, 8'd20);
    mode = 1;
    wait_quiet("early", 50);
    check("early_busy", {31'd0, busy_o}, 32'd0);
    mode = 0;
    repeat (4) @(negedge clk);

    // Timeout high after exactly 10 WAIT_HI cycles
    clear_logs();
    mode = 2;
    expect_end("tmo_hi", 1'b0, 1'b1, 2'b10, 8'd0);
    start_run(8'd1, 4'd1, 1'b0, 8'd10);
    wait_quiet("tmo_hi", 100);
    if (b_tog.size() > 0) check("tmo_hi_cycles", err_cyc - b_tog[0], 32'd10);
    else check("tmo_hi_b_rose", b_tog.size(), 32'd1);

    // Timeout disabled: controller keeps waiting until reset
    start_run(8'd1, 4'd1, 1'b0, 8'd0);
    repeat (300) @(negedge clk);
    check("tmo0_busy", {31'd0, busy_o}, 32'd1);
    check("tmo0_err", {31'd0, err_o}, 32'd0);
    expect_end("tmo0_rst", 1'b0, 1'b0, 2'b00, 8'd0);
    wb_rst_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("tmo0_rst");
    wb_rst_i = 1'b0;
    mode = 0;
    repeat (4) @(negedge clk);

    // Zero skew, b leads: simultaneous edges; stray starts ignored
    clear_logs();
    expect_end("skew0", 1'b1, 1'b0, 2'b00, 8'd2);
    start_run(8'd2, 4'd0, 1'b1, 8'd20);
    for (int i = 0; i < 3; i++) begin
      check("skew0_busy_at_pulse", {31'd0, busy_o}, 32'd1);
      start_i = 1'b1;
      n_cycles_i = 8'd7;
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
    end
    wait_quiet("skew0", 200);
    check("skew0_a_toggles", a_tog.size(), 32'd4);
    check("skew0_b_toggles", b_tog.size(), 32'd4);
    if (a_tog.size() == 4 && b_tog.size() == 4)
      for (int i = 0; i < 4; i++) check("skew0_same_cycle", b_tog[i] - a_tog[i], 32'd0);

    // Reset during WAIT_HI of the second handshake, then a clean run
    clear_logs();
    start_run(8'd3, 4'd3, 1'b0, 8'd20);
    k = 0;
    while (!(pass_cnt_o == 8'd1 && a_o === 1'b1 && b_o === 1'b1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      checks++;
      errors++;
      $display("FAIL midrst_reach_wait_hi actual=not_reached required=reached");
    end
    expect_end("midrst", 1'b0, 1'b0, 2'b00, 8'd0);
    wb_rst_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    wb_rst_i = 1'b0;
    repeat (4) @(negedge clk);
    expect_end("after_rst", 1'b1, 1'b0, 2'b00, 8'd2);
    start_run(8'd2, 4'd1, 1'b1, 8'd20);
    wait_quiet("after_rst", 300);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_expectations actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
